// File: rtl/touch_adc_reader_pkg.sv
// Shared types and constants for the touch-panel ADC reader.
package touch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONV_X,
    ST_CONV_Y,
    ST_UPDATE,
    ST_GAP
  } touch_state_t;

  localparam logic [7:0]  CMD_X        = 8'hD8;
  localparam logic [7:0]  CMD_Y        = 8'h98;
  localparam int unsigned FRAME_DCLKS  = 24;
  localparam int unsigned DATA_FIRST   = 10;
  localparam int unsigned DATA_LAST    = 17;
  // Setup half, two halves per DCLK, hold half.
  localparam int unsigned FRAME_HALVES = 2 * FRAME_DCLKS + 2;
  // Cycles already spent before SETTLE/GAP counting begins (detect/update, start register, CS fall).
  localparam int unsigned SEQ_PRELOAD  = 3;

endpackage

// File: rtl/touch_adc_reader_if.sv
// ADC serial bus plus coordinate outputs of the touch reader.
interface touch_adc_reader_if;
  logic       penirq_n;
  logic       adc_dout;
  logic       adc_busy;
  logic       adc_cs_n;
  logic       adc_dclk;
  logic       adc_din;
  logic [7:0] x_hold;
  logic [7:0] y_hold;
  logic       touch_valid;
  logic       touching;
  logic       busy_dbg;

  modport master (
    input  penirq_n, adc_dout, adc_busy,
    output adc_cs_n, adc_dclk, adc_din, x_hold, y_hold, touch_valid, touching, busy_dbg
  );

  modport slave (
    output penirq_n, adc_dout, adc_busy,
    input  adc_cs_n, adc_dclk, adc_din, x_hold, y_hold, touch_valid, touching, busy_dbg
  );
endinterface

// File: rtl/touch_adc_reader_spi_frame.sv
// One 24-DCLK AD7843 frame: CS sequencing, DCLK divider, command shift-out, 8-bit capture.
module touch_spi_frame
  import touch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_cmd,
  input  logic       i_dout,
  output logic       o_done,
  output logic [7:0] o_data,
  output logic       o_cs_n,
  output logic       o_dclk,
  output logic       o_din
);

  localparam int unsigned  DW        = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0]   HALF_LAST = 6'(FRAME_HALVES - 1);

  logic          r_busy;
  logic          r_pend;
  logic [DW-1:0] r_div;
  logic [5:0]    r_half;
  logic [7:0]    r_shift;
  logic          r_cs_n;
  logic          r_dclk;
  logic          r_din;
  logic          r_done;

  logic       w_div_end;
  logic [5:0] w_next_half;
  logic [5:0] w_per;
  logic [2:0] w_bit;

  assign w_div_end   = (r_div == DIV_LAST);
  assign w_next_half = r_half + 6'd1;
  // Odd halves are the low phase of DCLK (h+1)/2, even halves the high phase of DCLK h/2.
  assign w_per       = {1'b0, w_next_half[5:1]} + {5'b0, w_next_half[0]};
  assign w_bit       = 3'(6'd8 - w_per);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_div   <= '0;
      r_half  <= '0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_dclk  <= 1'b0;
      r_din   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        // r_div doubles as the CS-high guard: a new frame waits CLK_DIV cycles after CS rose.
        if (!w_div_end) r_div <= r_div + 1'b1;
        if (i_start) r_pend <= 1'b1;
        if ((i_start || r_pend) && w_div_end) begin
          r_busy <= 1'b1;
          r_pend <= 1'b0;
          r_cs_n <= 1'b0;
          r_div  <= '0;
          r_half <= '0;
        end
      end else if (!w_div_end) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div <= '0;
        if (r_half == HALF_LAST) begin
          r_busy <= 1'b0;
          r_cs_n <= 1'b1;
          r_done <= 1'b1;
          r_half <= '0;
        end else begin
          r_half <= w_next_half;
          r_dclk <= ~w_next_half[0];
          if (w_next_half[0]) begin
            r_din <= (w_per <= 6'd8) ? i_cmd[w_bit] : 1'b0;
          end else if (w_per >= 6'(DATA_FIRST) && w_per <= 6'(DATA_LAST)) begin
            r_shift <= {r_shift[6:0], i_dout};
          end
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_data = r_shift;
  assign o_cs_n = r_cs_n;
  assign o_dclk = r_dclk;
  assign o_din  = r_din;

endmodule

// File: rtl/touch_adc_reader.sv
// Touch-panel reader: pen-IRQ synchronizer, X/Y conversion sequencer and coordinate hold registers.
module touch_adc_reader
  import touch_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned SETTLE_CYC = 5000,
  parameter int unsigned GAP_CYC    = 50000
) (
  input logic               clk,
  input logic               reset,
  touch_adc_reader_if.master bus
);

  touch_state_t r_state;
  logic [31:0]  r_cnt;
  logic         r_start;
  logic [7:0]   r_cmd;
  logic [7:0]   r_x_cap;
  logic [7:0]   r_x_hold;
  logic [7:0]   r_y_hold;
  logic         r_valid;
  logic         r_meta;
  logic         r_touching;
  logic         r_busy_dbg;

  logic         w_done;
  logic [7:0]   w_data;

  touch_spi_frame #(
    .CLK_DIV(CLK_DIV)
  ) u_frame (
    .clk    (clk),
    .reset  (reset),
    .i_start(r_start),
    .i_cmd  (r_cmd),
    .i_dout (bus.adc_dout),
    .o_done (w_done),
    .o_data (w_data),
    .o_cs_n (bus.adc_cs_n),
    .o_dclk (bus.adc_dclk),
    .o_din  (bus.adc_din)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_cmd      <= '0;
      r_x_cap    <= '0;
      r_x_hold   <= '0;
      r_y_hold   <= '0;
      r_valid    <= 1'b0;
      r_meta     <= 1'b1;
      r_touching <= 1'b0;
      r_busy_dbg <= 1'b0;
    end else begin
      r_meta     <= bus.penirq_n;
      r_touching <= ~r_meta;
      r_busy_dbg <= bus.adc_busy;
      r_start    <= 1'b0;
      r_valid    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_touching) begin
            r_state <= ST_SETTLE;
            r_cnt   <= 32'(SEQ_PRELOAD);
          end
        end
        ST_SETTLE: begin
          if (!r_touching) begin
            r_state <= ST_IDLE;
          end else if (r_cnt >= 32'(SETTLE_CYC)) begin
            r_state <= ST_CONV_X;
            r_start <= 1'b1;
            r_cmd   <= CMD_X;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_CONV_X: begin
          if (w_done) begin
            r_x_cap <= w_data;
            r_state <= ST_CONV_Y;
            r_start <= 1'b1;
            r_cmd   <= CMD_Y;
          end
        end
        ST_CONV_Y: begin
          // Holds load on the edge ending the Y frame so touch_valid coincides with the UPDATE cycle.
          if (w_done) begin
            r_state <= ST_UPDATE;
            if (r_touching) begin
              r_x_hold <= r_x_cap;
              r_y_hold <= w_data;
              r_valid  <= 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          r_state <= ST_GAP;
          r_cnt   <= 32'(SEQ_PRELOAD);
        end
        ST_GAP: begin
          if (r_cnt >= 32'(GAP_CYC)) begin
            if (r_touching) begin
              r_state <= ST_CONV_X;
              r_start <= 1'b1;
              r_cmd   <= CMD_X;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.x_hold      = r_x_hold;
  assign bus.y_hold      = r_y_hold;
  assign bus.touch_valid = r_valid;
  assign bus.touching    = r_touching;
  assign bus.busy_dbg    = r_busy_dbg;

endmodule

// File: doc/touch_adc_reader.md
# touch_adc_reader

Serial front end for the LTM touch-panel ADC, an AD7843-compatible part. When the pen-interrupt line reports a touch, the block runs SPI conversions for X then Y and presents 8-bit coordinates on `x_hold`/`y_hold`. Those outputs drive the touch-to-button decoder downstream. This block is the producer for the coordinate/button path: it acquires the coordinates that the decoder consumes.

## Interface
Parameters:
- `CLK_DIV`, default 25: system clocks per DCLK half-period (50 MHz gives 1 MHz DCLK). Legal range ≥2.
- `SETTLE_CYC`, default 5000: system clocks to wait after touch detect before the first frame.
- `GAP_CYC`, default 50000: system clocks in IDLE-gap between sample pairs while the pen stays down.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  async active-high reset.
- `penirq_n`  in  1  ADC pen interrupt, active low, asynchronous to `clk`.
- `adc_dout`  in  1  ADC serial data out.
- `adc_busy`  in  1  ADC busy. Ignored functionally; captured for debug only.
- `adc_cs_n`  out  1  chip select, active low.
- `adc_dclk`  out  1  serial clock.
- `adc_din`  out  1  serial command data.
- `x_hold`  out  8  last valid X coordinate.
- `y_hold`  out  8  last valid Y coordinate.
- `touch_valid`  out  1  one-cycle pulse when `x_hold`/`y_hold` update.
- `touching`  out  1  synchronized, inverted `penirq_n`.

## Operation
- `penirq_n` passes through a 2-FF synchronizer. `touching` = NOT(synchronized value).
- States:
  - IDLE → SETTLE when `touching`=1.
  - SETTLE counts `SETTLE_CYC`, then goes to CONV_X. If `touching` drops during SETTLE, return to IDLE.
  - CONV_X runs one frame with command 8'hD8 (start, A=101, 8-bit mode, differential, PD=00), then goes to CONV_Y.
  - CONV_Y runs one frame with command 8'h98 (A=001), then goes to UPDATE.
  - UPDATE lasts one cycle. If `touching`=1, load `x_hold`/`y_hold` from the captured values and pulse `touch_valid`; otherwise discard both samples. Then go to GAP.
  - GAP counts `GAP_CYC`, then goes to CONV_X if `touching`=1, else IDLE.
- Frame structure:
  - `adc_cs_n` falls, followed by one half-period of setup, then 24 DCLK periods, each low-then-high.
  - DCLK 1–8: `adc_din` carries the command MSB-first. It changes at the start of the low phase and is stable at the rising edge.
  - DCLK 9: busy cycle; `adc_din`=0.
  - DCLK 10–17: `adc_dout` is sampled on the rising edge, MSB first, into the shift register.
  - DCLK 18–24: padding; `adc_din`=0.
  - After the last high phase, `adc_dclk` returns to 0, followed by one half-period of hold, then `adc_cs_n` rises.
  - `adc_cs_n` stays high for at least `CLK_DIV` cycles between the X and Y frames.
- A pen release mid-frame does not abort the frame. The frame completes and its result is discarded at UPDATE.
- Reset, including reset asserted mid-frame, forces immediately: state IDLE, `adc_cs_n`=1, `adc_dclk`=0, `adc_din`=0, `x_hold`=0, `y_hold`=0, `touch_valid`=0, `touching`=0. Counters and shift registers clear.

## Timing
- DCLK period = 2·`CLK_DIV` clocks. Frame length including setup/hold = 50·`CLK_DIV` clocks.
- Touch to first `touch_valid` = 2 (sync) + `SETTLE_CYC` + 101·`CLK_DIV` (X frame, CS gap, Y frame) + 1 (UPDATE). With `CLK_DIV`=2 and `SETTLE_CYC`=10, this is 215 cycles.
- Repeat period while held = 101·`CLK_DIV` + 1 + `GAP_CYC`.
- `x_hold`/`y_hold` change only in the UPDATE cycle and hold otherwise. `touch_valid` is high in the same cycle the new values appear.

## Structure
- Package `touch_pkg`: state enum, `CMD_X`=8'hD8, `CMD_Y`=8'h98, `FRAME_DCLKS`=24, `DATA_FIRST`=10, `DATA_LAST`=17.
- Sub-module `touch_spi_frame`:
  - Handshake: `start` in, `done` pulse out.
  - Inputs: 8-bit `cmd`. Output: 8-bit `data`.
  - Owns the DCLK divider, CS sequencing and the shift registers.
- The top level holds the synchronizer, the sequencing FSM, the SETTLE/GAP counters and the hold registers.

## Test plan
All scenarios use `CLK_DIV`=2, `SETTLE_CYC`=10, `GAP_CYC`=20.
- Reset with `penirq_n`=1 → all outputs 0, `adc_cs_n`=1; no DCLK edges for 1000 cycles.
- `penirq_n`=0 held; ADC model returns 8'hA5 for X and 8'h3C for Y → `touch_valid` pulses at cycle 215 with `x_hold`=A5, `y_hold`=3C; captured `adc_din` streams are D8 then 98.
- Pen held while the model returns X=8'h01/Y=8'hFE, then X=8'h80/Y=8'h7F → two `touch_valid` pulses 223 cycles apart with matching values.
- `penirq_n` released during the Y frame → frame finishes; no `touch_valid`; `x_hold`/`y_hold` keep prior values; FSM returns to IDLE after GAP.
- `penirq_n` pulses low for 5 cycles (less than SETTLE) → no frame is started; `adc_cs_n` stays high.
- `reset` asserted during DCLK 12 of the X frame → `adc_cs_n`=1, `adc_dclk`=0 and `x_hold`=0 within the same cycle; after release with the pen down, a clean full sequence follows.
